// File: rtl/bin_maxpool_2x2_pkg.sv
// Shared constants, legal map sizes and FSM state encoding for the 2x2 binary max-pool engine.
package bin_maxpool_2x2_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] TERM_WORD = 16'h00FF;

  localparam logic [DATA_W-1:0] N_LEGAL_0 = 16'd8;
  localparam logic [DATA_W-1:0] N_LEGAL_1 = 16'd10;
  localparam logic [DATA_W-1:0] N_LEGAL_2 = 16'd14;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    EVEN = 3'd2,
    ODD  = 3'd3,
    TERM = 3'd4
  } state_t;

  // Any header other than a supported map size ends the map list.
  function automatic logic is_legal_n(input logic [DATA_W-1:0] hdr);
    return (hdr == N_LEGAL_0) || (hdr == N_LEGAL_1) || (hdr == N_LEGAL_2);
  endfunction

endpackage

// File: rtl/bin_maxpool_2x2_if.sv
// SRAM-side bus of the max-pool engine: a read port into the convolution results and a write port for pooled words.
interface bin_maxpool_2x2_if #(
  parameter int AW = bin_maxpool_2x2_pkg::ADDR_W,
  parameter int DW = bin_maxpool_2x2_pkg::DATA_W
);
  logic [AW-1:0] dut_sram_read_address;
  logic [DW-1:0] sram_dut_read_data;
  logic [AW-1:0] dut_sram_write_address;
  logic [DW-1:0] dut_sram_write_data;
  logic          dut_sram_write_enable;

  modport master (
    output dut_sram_read_address,
    input  sram_dut_read_data,
    output dut_sram_write_address,
    output dut_sram_write_data,
    output dut_sram_write_enable
  );

  modport slave (
    input  dut_sram_read_address,
    output sram_dut_read_data,
    input  dut_sram_write_address,
    input  dut_sram_write_data,
    input  dut_sram_write_enable
  );
endinterface

// File: rtl/bin_maxpool_2x2_pool_row_or.sv
// Combinational 2x2 OR-pool of one row pair: output bit j covers columns 2j and 2j+1 of both rows.
module pool_row_or
  import bin_maxpool_2x2_pkg::*;
(
  input  logic [15:0] row_even,
  input  logic [15:0] row_odd,
  input  logic [3:0]  n,
  output logic [15:0] pooled
);

  // Columns at or beyond n carry no pixels, so only the first n/2 output bits are populated.
  always_comb begin
    pooled = 16'h0000;
    for (int j = 0; j < 8; j++) begin
      if ((2 * j + 2) <= int'(n)) begin
        pooled[j] = row_even[2*j] | row_even[2*j+1] | row_odd[2*j] | row_odd[2*j+1];
      end else begin
        pooled[j] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bin_maxpool_2x2.sv
// Streams binary feature maps from SRAM, OR-pools each 2x2 block and writes the halved maps plus a terminator.
module bin_maxpool_2x2 #(
  parameter int ADDR_W = bin_maxpool_2x2_pkg::ADDR_W,
  parameter int DATA_W = bin_maxpool_2x2_pkg::DATA_W,
  parameter logic [DATA_W-1:0] TERM_WORD = bin_maxpool_2x2_pkg::TERM_WORD
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              dut_run,
  output logic              dut_busy,
  bin_maxpool_2x2_if.master sram
);
  import bin_maxpool_2x2_pkg::*;

  state_t      state_r;
  logic [3:0]  n_r;
  logic [2:0]  pair_r;
  logic [15:0] even_r;
  logic [15:0] pooled_s;

  pool_row_or u_pool (
    .row_even (even_r),
    .row_odd  (sram.sram_dut_read_data),
    .n        (n_r),
    .pooled   (pooled_s)
  );

  // Even-row buffer holds its row until the odd partner arrives; no reset needed.
  always_ff @(posedge clk) begin
    if (state_r == EVEN) begin
      even_r <= sram.sram_dut_read_data;
    end
  end

  // Control FSM. The state names what the read data currently is, since the address
  // for each word is issued one cycle ahead and reads run back to back within a map.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_r                     <= IDLE;
      dut_busy                    <= 1'b0;
      n_r                         <= 4'd0;
      pair_r                      <= 3'd0;
      sram.dut_sram_read_address  <= '0;
      sram.dut_sram_write_address <= '0;
      sram.dut_sram_write_data    <= '0;
      sram.dut_sram_write_enable  <= 1'b0;
    end else begin
      if (sram.dut_sram_write_enable) begin
        sram.dut_sram_write_address <= sram.dut_sram_write_address + ADDR_W'(1);
      end
      sram.dut_sram_write_enable <= 1'b0;
      case (state_r)
        IDLE: begin
          if (dut_run) begin
            state_r                    <= HDR;
            dut_busy                   <= 1'b1;
            sram.dut_sram_read_address <= sram.dut_sram_read_address + ADDR_W'(1);
          end
        end
        HDR: begin
          sram.dut_sram_write_enable <= 1'b1;
          if (is_legal_n(sram.sram_dut_read_data)) begin
            state_r                    <= EVEN;
            n_r                        <= sram.sram_dut_read_data[3:0];
            pair_r                     <= 3'd0;
            sram.dut_sram_write_data   <= sram.sram_dut_read_data >> 1;
            sram.dut_sram_read_address <= sram.dut_sram_read_address + ADDR_W'(1);
          end else begin
            state_r                  <= TERM;
            sram.dut_sram_write_data <= TERM_WORD;
          end
        end
        EVEN: begin
          state_r                    <= ODD;
          sram.dut_sram_read_address <= sram.dut_sram_read_address + ADDR_W'(1);
        end
        ODD: begin
          sram.dut_sram_write_enable <= 1'b1;
          sram.dut_sram_write_data   <= DATA_W'(pooled_s);
          sram.dut_sram_read_address <= sram.dut_sram_read_address + ADDR_W'(1);
          pair_r                     <= pair_r + 3'd1;
          state_r                    <= ((pair_r + 3'd1) == n_r[3:1]) ? HDR : EVEN;
        end
        TERM: begin
          state_r                     <= IDLE;
          dut_busy                    <= 1'b0;
          sram.dut_sram_read_address  <= '0;
          sram.dut_sram_write_address <= '0;
        end
        default: begin
          state_r                     <= IDLE;
          dut_busy                    <= 1'b0;
          sram.dut_sram_read_address  <= '0;
          sram.dut_sram_write_address <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_maxpool_2x2.sv
// Scoreboard bench for bin_maxpool_2x2: directed maps, expected writes queued, a negedge monitor compares strobes.
module tb_bin_maxpool_2x2;

  typedef struct packed {
    logic [11:0] addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset_b = 1'b0;
  logic dut_run = 1'b0;
  logic dut_busy;
  logic [15:0] mem [0:4095];
  wr_t exp_q[$];
  wr_t got_e;
  bit chk_en = 1'b1;
  int checks = 0;
  int errors = 0;

  bin_maxpool_2x2_if bus ();

  bin_maxpool_2x2 dut (
    .clk      (clk),
    .reset_b  (reset_b),
    .dut_run  (dut_run),
    .dut_busy (dut_busy),
    .sram     (bus)
  );

  always #5 clk = ~clk;

  // SRAM read port model: data valid one cycle after the address.
  always @(posedge clk) bus.sram_dut_read_data <= mem[bus.dut_sram_read_address];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the next expected write.
  always @(negedge clk) begin
    if (reset_b && chk_en && bus.dut_sram_write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 bus.dut_sram_write_address, bus.dut_sram_write_data);
      end else begin
        got_e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.dut_sram_write_address), 32'(got_e.addr));
        chk("wr_data", 32'(bus.dut_sram_write_data), 32'(got_e.data));
      end
    end
  end

  task automatic expw(input int addr, input logic [15:0] data);
    wr_t w;
    w.addr = 12'(addr);
    w.data = data;
    exp_q.push_back(w);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, 32'(dut_busy), 32'h0);
    chk({tag, "_raddr"}, 32'(bus.dut_sram_read_address), 32'h0);
    chk({tag, "_waddr"}, 32'(bus.dut_sram_write_address), 32'h0);
    chk({tag, "_wdata"}, 32'(bus.dut_sram_write_data), 32'h0);
    chk({tag, "_we"}, 32'(bus.dut_sram_write_enable), 32'h0);
  endtask

  task automatic run_map(input string name, input int exp_busy, input bit pulse);
    int cnt;
    @(negedge clk);
    dut_run = 1'b1;
    @(negedge clk);
    dut_run = 1'b0;
    cnt = 0;
    while (dut_busy === 1'b1 && cnt < 200) begin
      cnt++;
      if (pulse) dut_run = cnt[1];
      @(negedge clk);
    end
    dut_run = 1'b0;
    chk({name, "_busy_cycles"}, 32'(cnt), 32'(exp_busy));
    repeat (4) @(negedge clk);
    chk({name, "_all_writes_seen"}, 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  task automatic load_t1();
    clear_mem();
    mem[0] = 16'd8;
    mem[4] = 16'h0080;
    mem[9] = 16'h00FF;
  endtask

  task automatic exp_t1();
    expw(0, 16'h0004); expw(1, 16'h0000); expw(2, 16'h0008);
    expw(3, 16'h0000); expw(4, 16'h0000); expw(5, 16'h00FF);
  endtask

  task automatic load_t2();
    clear_mem();
    mem[0] = 16'd14;
    for (int i = 0; i < 14; i++) mem[1+i] = (i % 2 == 0) ? 16'h3FFF : 16'h0000;
    mem[15] = 16'h00FF;
  endtask

  task automatic exp_t2();
    expw(0, 16'h0007);
    for (int i = 1; i <= 7; i++) expw(i, 16'h007F);
    expw(8, 16'h00FF);
  endtask

  initial begin
    clear_mem();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset_b = 1'b1;

    load_t1(); exp_t1();
    run_map("t1_n8", 11, 1'b0);

    load_t2(); exp_t2();
    run_map("t2_n14", 17, 1'b0);

    // Three maps; columns above N-1 set in maps A and C must be ignored.
    clear_mem();
    mem[0] = 16'd10;
    for (int i = 1; i <= 10; i++) mem[i] = 16'hFFFF;
    mem[11] = 16'd8;
    mem[12] = 16'h0003;
    mem[20] = 16'd14;
    for (int i = 21; i <= 34; i++) mem[i] = 16'hE000;
    mem[35] = 16'h00FF;
    expw(0, 16'h0005);
    for (int i = 1; i <= 5; i++) expw(i, 16'h001F);
    expw(6, 16'h0004); expw(7, 16'h0001);
    expw(8, 16'h0000); expw(9, 16'h0000); expw(10, 16'h0000);
    expw(11, 16'h0007);
    for (int i = 12; i <= 18; i++) expw(i, 16'h0040);
    expw(19, 16'h00FF);
    run_map("t3_multi", 37, 1'b0);

    clear_mem();
    mem[0] = 16'h000C;
    expw(0, 16'h00FF);
    run_map("t4_illegal", 2, 1'b0);

    // Reset in the middle of a map, then an uninterrupted rerun.
    load_t1();
    chk_en = 1'b0;
    @(negedge clk);
    dut_run = 1'b1;
    @(negedge clk);
    dut_run = 1'b0;
    repeat (4) @(negedge clk);
    reset_b = 1'b0;
    @(negedge clk);
    check_outputs_zero("midreset");
    reset_b = 1'b1;
    chk_en = 1'b1;
    exp_t1();
    run_map("t5_rerun", 11, 1'b0);

    load_t2(); exp_t2();
    run_map("t6_run_pulses", 17, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
